// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner, imem request/ack handshake, registered if_* stage with 1-entry skid.
// Optional FETCH_COUNT_EN adds fetch_count output counting instructions delivered into if_*.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [15:0] if_imm16,
`ifdef FETCH_COUNT_EN
    output logic [31:0] fetch_count,
`endif
    output logic [1:0]  if_ext_op
);
    typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;
    state_t state, state_n;
    logic [31:0] pc, pc_n, addr_n, skid_instr, skid_pc, load_word, load_pc;
    logic req_n, kill, kill_n, load, skid_we, clr_valid, slot_free;
    function automatic logic [1:0] ext_of(input logic [5:0] op);
        return op == 6'h0F ? 2'b01 : (op >= 6'h0C && op <= 6'h0E) ? 2'b10 : 2'b00;
    endfunction
    assign slot_free = !if_valid || !stall;
    always_comb begin
        state_n = state;
        pc_n = pc;
        req_n = imem_req;
        addr_n = imem_addr;
        kill_n = kill;
        load = 1'b0;
        load_word = imem_rdata;
        load_pc = pc;
        skid_we = 1'b0;
        clr_valid = !stall;
        if (redirect) begin
            pc_n = redirect_pc & ~32'h3;
            clr_valid = 1'b1;
            // an unacked request must stay up, so its eventual data is marked for discard
            kill_n = imem_req && !imem_ack;
            req_n = kill_n;
            state_n = kill_n ? WAIT : FETCH;
        end else begin
            case (state)
                FETCH: if (slot_free) begin
                    req_n = 1'b1;
                    addr_n = pc;
                    state_n = WAIT;
                end
                WAIT: if (imem_ack) begin
                    if (kill) begin
                        kill_n = 1'b0;
                        req_n = 1'b0;
                        state_n = FETCH;
                    end else if (slot_free) begin
                        load = 1'b1;
                        pc_n = pc + 32'd4;
                        addr_n = pc + 32'd4;
                    end else begin
                        skid_we = 1'b1;
                        pc_n = pc + 32'd4;
                        req_n = 1'b0;
                        state_n = DRAIN;
                    end
                end
                DRAIN: if (!stall) begin
                    load = 1'b1;
                    load_word = skid_instr;
                    load_pc = skid_pc;
                    state_n = FETCH;
                end
                default: state_n = FETCH;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc <= RESET_PC;
            imem_req <= 1'b0;
            imem_addr <= RESET_PC;
            kill <= 1'b0;
            skid_instr <= '0;
            skid_pc <= '0;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc <= '0;
            if_imm16 <= '0;
            if_ext_op <= '0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            imem_req <= req_n;
            imem_addr <= addr_n;
            kill <= kill_n;
            if (skid_we) begin
                skid_instr <= imem_rdata;
                skid_pc <= pc;
            end
            if (load) begin
                if_valid <= 1'b1;
                if_instr <= load_word;
                if_pc <= load_pc;
                if_imm16 <= load_word[15:0];
                if_ext_op <= ext_of(load_word[31:26]);
            end else if (clr_valid) begin
                if_valid <= 1'b0;
            end
        end
    end
`ifdef FETCH_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_count <= '0;
        else if (load) fetch_count <= fetch_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of fetch flow, skid, redirect/kill, pre-decode, wrap and reset.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req, imem_ack, stall, redirect, if_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, if_instr, if_pc;
    logic [15:0] if_imm16;
    logic [1:0]  if_ext_op;
    logic        zw, ack_man;
    logic [31:0] rdata_man;
    logic [15:0] mem_hi;
    int          passed = 0, total = 0;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif
    assign imem_ack = zw ? imem_req : ack_man;
    assign imem_rdata = zw ? {mem_hi, imem_addr[15:0]} : rdata_man;
    always #5 clk = ~clk;
    instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc(if_pc), .if_imm16(if_imm16),
`ifdef FETCH_COUNT_EN
        .fetch_count(fetch_count),
`endif
        .if_ext_op(if_ext_op)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        stall = 0; redirect = 0; redirect_pc = '0;
        zw = 1; ack_man = 0; rdata_man = '0; mem_hi = 16'h2000;
        #1 rst_n = 0;
        #2;
        chk("rst_req", {31'd0, imem_req}, 0);
        chk("rst_addr", imem_addr, 32'h100);
        chk("rst_valid", {31'd0, if_valid}, 0);
        chk("rst_instr", if_instr, 0);
        #9 rst_n = 1;
        tick;
        chk("t1_req", {31'd0, imem_req}, 1);
        chk("t1_addr", imem_addr, 32'h100);
        chk("t1_valid0", {31'd0, if_valid}, 0);
        tick;
        chk("t1_valid", {31'd0, if_valid}, 1);
        chk("t1_pc0", if_pc, 32'h100);
        chk("t1_instr0", if_instr, 32'h2000_0100);
        tick;
        chk("t1_pc1", if_pc, 32'h104);
        tick;
        chk("t1_pc2", if_pc, 32'h108);
        chk("t1_ext", {30'd0, if_ext_op}, 0);
        chk("t1_addr3", imem_addr, 32'h10C);
        zw = 0; stall = 1; ack_man = 1; rdata_man = 32'h3C01_1234;
        tick;
        ack_man = 0;
        chk("t2_req", {31'd0, imem_req}, 0);
        chk("t2_pc_hold", if_pc, 32'h108);
        chk("t2_instr_hold", if_instr, 32'h2000_0108);
        tick;
        tick;
        chk("t2_valid_hold", {31'd0, if_valid}, 1);
        chk("t2_instr_hold2", if_instr, 32'h2000_0108);
        chk("t2_req2", {31'd0, imem_req}, 0);
        stall = 0;
        tick;
        chk("t2_instr", if_instr, 32'h3C01_1234);
        chk("t2_ext", {30'd0, if_ext_op}, 1);
        chk("t2_imm", {16'd0, if_imm16}, 32'h1234);
        chk("t2_pc", if_pc, 32'h10C);
        tick;
        chk("t2_relaunch", imem_addr, 32'h110);
        chk("t2_bubble", {31'd0, if_valid}, 0);
        tick;
        chk("t3_wait_req", {31'd0, imem_req}, 1);
        redirect = 1; redirect_pc = 32'h203;
        tick;
        redirect = 0;
        chk("t3_valid", {31'd0, if_valid}, 0);
        chk("t3_addr_held", imem_addr, 32'h110);
        ack_man = 1; rdata_man = 32'h1111_1111;
        tick;
        ack_man = 0;
        chk("t3_discard", {31'd0, if_valid}, 0);
        chk("t3_req_drop", {31'd0, imem_req}, 0);
        tick;
        chk("t3_new_req", {31'd0, imem_req}, 1);
        chk("t3_new_addr", imem_addr, 32'h200);
        chk("t3_still_empty", {31'd0, if_valid}, 0);
        ack_man = 1; rdata_man = 32'h3422_8000;
        tick;
        ack_man = 0;
        chk("t5_ori_pc", if_pc, 32'h200);
        chk("t5_ori_ext", {30'd0, if_ext_op}, 2);
        chk("t5_ori_imm", {16'd0, if_imm16}, 32'h8000);
        ack_man = 1; rdata_man = 32'h2022_FFFF; redirect = 1; redirect_pc = 32'hFFFF_FFFE;
        tick;
        ack_man = 0; redirect = 0;
        chk("t4_valid", {31'd0, if_valid}, 0);
        chk("t4_req", {31'd0, imem_req}, 0);
        tick;
        chk("t4_addr", imem_addr, 32'hFFFF_FFFC);
        ack_man = 1;
        tick;
        ack_man = 0;
        chk("t5_addi_ext", {30'd0, if_ext_op}, 0);
        chk("t5_addi_pc", if_pc, 32'hFFFF_FFFC);
        chk("t5_wrap", imem_addr, 32'h0);
`ifdef FETCH_COUNT_EN
        chk("t6_count", fetch_count, 32'd6);
`endif
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("t6_req", {31'd0, imem_req}, 0);
        chk("t6_addr", imem_addr, 32'h100);
        chk("t6_valid", {31'd0, if_valid}, 0);
        chk("t6_pc", if_pc, 32'h0);
`ifdef FETCH_COUNT_EN
        chk("t6_count_rst", fetch_count, 32'd0);
`endif
        ack_man = 1; rdata_man = 32'hDEAD_BEEF;
        #1 rst_n = 1;
        tick;
        chk("t6_late_ack", {31'd0, if_valid}, 0);
        chk("t6_launch", imem_addr, 32'h100);
        ack_man = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
